// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: CPU RAM/I-O responder with a byte-stream program loader that holds the CPU during loads.
// Optional I/O registers at IO_BASE/IO_BASE+1 are built when MEM_IO_PORT_EN is defined.
module cpu_mem_responder #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [15:0] IO_BASE   = 16'hD000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        we,
  output logic [7:0]  din,
  output logic        cpu_hold,
  input  logic        ld_start,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_overflow,
  output logic [7:0]  io_out,
  input  logic [7:0]  io_in
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic ovf_q, ovf_d;
  logic [7:0] din_q, din_d, io_out_q, io_out_d;
  logic [7:0] mem_q [MEM_DEPTH];
  logic mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic ram_sel, io_out_sel, io_in_sel;
  assign ram_sel = addr < 16'(MEM_DEPTH);
`ifdef MEM_IO_PORT_EN
  assign io_out_sel = addr == IO_BASE;
  assign io_in_sel  = addr == IO_BASE + 16'd1;
`else
  assign io_out_sel = 1'b0;
  assign io_in_sel  = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ovf_d     = ovf_q;
    mem_we    = state_q == RUN && we && ram_sel;
    mem_waddr = addr[AW-1:0];
    mem_wdata = dout;
    if (ld_start) begin
      state_d = LOAD;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == LOAD && ld_valid) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = ld_data;
      ptr_d     = ptr_q + AW'(1);
      ovf_d     = ovf_q | (&ptr_q);
      state_d   = ld_last ? RELEASE : LOAD;
    end else if (state_q == RELEASE) begin
      state_d = RUN;
    end
  end
  assign io_out_d = (state_q == RUN && we && io_out_sel) ? dout : io_out_q;
  // Registered read of the pre-write contents gives read-before-write.
  assign din_d = ram_sel ? mem_q[addr[AW-1:0]] : io_out_sel ? io_out_q : io_in_sel ? io_in : 8'h00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      din_q    <= 8'h00;
      io_out_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      din_q    <= din_d;
      io_out_q <= io_out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end
  assign din         = din_q;
  assign io_out      = io_out_q;
  assign ld_overflow = ovf_q;
  assign cpu_hold    = state_q != RUN;
  assign ld_ready    = state_q == LOAD;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: randomized self-checking bench against a byte-array model of RAM, I/O and loader.
module tb_cpu_mem_responder;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0] dout = '0, din, ld_data = '0, io_out, io_in = '0;
  logic we = 1'b0, cpu_hold, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, ld_ready, ld_overflow;
  int n_chk = 0, n_fail = 0;
  logic [7:0] ref_mem [256];
  bit ref_known [256];
  logic [7:0] ref_io = 8'h00;
  bit ref_ovf = 1'b0;
  int ref_ptr = 0;
  logic [7:0] lq [$];
  always #5 clk = ~clk;
  cpu_mem_responder #(.MEM_DEPTH(256), .IO_BASE(16'hD000)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dout(dout), .we(we), .din(din),
    .cpu_hold(cpu_hold), .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_overflow(ld_overflow),
    .io_out(io_out), .io_in(io_in)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic bit model_rd(input logic [15:0] a, output logic [7:0] v);
    v = 8'h00;
    if (a < 16'd256) begin
      v = ref_mem[a[7:0]];
      return ref_known[a[7:0]];
    end
`ifdef MEM_IO_PORT_EN
    if (a == 16'hD000) v = ref_io;
    else if (a == 16'hD001) v = io_in;
`endif
    return 1'b1;
  endfunction
  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 16'($urandom_range(0, 255));
      2:       return 16'h0100 + 16'($urandom_range(0, 255));
      3:       return 16'hD000;
      4:       return 16'hD001;
      default: return 16'($urandom);
    endcase
  endfunction
  task automatic cpu_op(input logic [15:0] a, input bit w, input logic [7:0] d);
    logic [7:0] v;
    bit k;
    addr = a; we = w; dout = d;
    ld_valid = 1'($urandom_range(0, 1)); ld_data = 8'($urandom); ld_last = 1'($urandom_range(0, 1));
    k = model_rd(a, v);
    step();
    if (k) check($sformatf("din@%h", a), din, v);
    if (w && a < 16'd256) begin
      ref_mem[a[7:0]] = d;
      ref_known[a[7:0]] = 1'b1;
    end
`ifdef MEM_IO_PORT_EN
    if (w && a == 16'hD000) ref_io = d;
`endif
    check("io_out", io_out, ref_io);
    check("ready_run", ld_ready, 0);
    check("hold_run", cpu_hold, 0);
    check("ovf_run", ld_overflow, ref_ovf);
    we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
  endtask
  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ref_ptr = 0;
    ref_ovf = 1'b0;
    check("hold_start", cpu_hold, 1);
    check("ready_start", ld_ready, 1);
    check("ovf_start", ld_overflow, 0);
  endtask
  task automatic send(input logic [7:0] b, input bit last, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      ld_valid = 1'b0; we = 1'b1; addr = rand_addr(); dout = 8'($urandom);
      step();
      check("ready_gap", ld_ready, 1);
      check("hold_gap", cpu_hold, 1);
    end
    we = 1'($urandom_range(0, 1)); addr = rand_addr(); dout = 8'($urandom);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    step();
    ref_mem[ref_ptr] = b;
    ref_known[ref_ptr] = 1'b1;
    if (ref_ptr == 255) ref_ovf = 1'b1;
    ref_ptr = (ref_ptr + 1) % 256;
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ovf_load", ld_overflow, ref_ovf);
    if (last) begin
      check("hold_rel", cpu_hold, 1);
      check("ready_rel", ld_ready, 0);
      we = 1'b1; addr = rand_addr(); dout = 8'($urandom);
      step();
      check("hold_done", cpu_hold, 0);
      check("ready_done", ld_ready, 0);
    end else begin
      check("ready_load", ld_ready, 1);
    end
    we = 1'b0;
  endtask
  task automatic load_q(input bit gaps);
    start_load();
    foreach (lq[i]) send(lq[i], i == lq.size() - 1, gaps);
  endtask
  initial begin
    repeat (2) step();
    check("rst_din", din, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_ovf", ld_overflow, 0);
    check("rst_io", io_out, 0);
    reset = 1'b1;
    step();
    lq = '{8'hA9, 8'h03, 8'h38, 8'hE9, 8'h02};
    load_q(1'b0);
    for (int i = 0; i < 5; i++) cpu_op(16'(i), 1'b0, 8'h00);
    cpu_op(16'h0001, 1'b0, 8'h00);
    cpu_op(16'h5000, 1'b0, 8'h00);
    cpu_op(16'h0010, 1'b1, 8'h11);
    cpu_op(16'h0010, 1'b1, 8'h5A);
    cpu_op(16'h0010, 1'b0, 8'h00);
    io_in = 8'h7E;
    cpu_op(16'hD000, 1'b1, 8'hC3);
    cpu_op(16'hD000, 1'b0, 8'h00);
    cpu_op(16'hD001, 1'b0, 8'h00);
    cpu_op(16'hD001, 1'b1, 8'h99);
    cpu_op(16'hD000, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      io_in = 8'($urandom);
      cpu_op(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    for (int n = 0; n < 4; n++) begin
      lq.delete();
      repeat ($urandom_range(1, 20)) lq.push_back(8'($urandom));
      load_q(1'b1);
      for (int i = 0; i < 40; i++) cpu_op(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom));
      for (int i = 0; i < 24; i++) cpu_op(16'(i), 1'b0, 8'h00);
    end
    start_load();
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b0);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
    step();
    ld_start = 1'b0; ld_valid = 1'b0;
    ref_ptr = 0;
    ref_ovf = 1'b0;
    check("hold_restart", cpu_hold, 1);
    check("ready_restart", ld_ready, 1);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cpu_op(16'(i), 1'b0, 8'h00);
    lq.delete();
    repeat (257) lq.push_back(8'($urandom));
    load_q(1'b0);
    check("ovf_set", ld_overflow, 1);
    cpu_op(16'h0000, 1'b0, 8'h00);
    cpu_op(16'h0001, 1'b0, 8'h00);
    cpu_op(16'h00FF, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    check("rst2_ovf", ld_overflow, 0);
    step();
    reset = 1'b1;
    ref_ovf = 1'b0;
    ref_io = 8'h00;
    check("rst2_io", io_out, 0);
    start_load();
    send(8'hB1, 1'b0, 1'b1);
    send(8'hB2, 1'b0, 1'b1);
    send(8'hB3, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_hold", cpu_hold, 0);
    check("mid_ready", ld_ready, 0);
    check("mid_ovf", ld_overflow, 0);
    check("mid_din", din, 0);
    step();
    reset = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < 4; i++) cpu_op(16'(i), 1'b0, 8'h00);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
